// File: rtl/retire_stage_pkg.sv
// rtl/retire_stage_pkg.sv - sys_defs package: retire-stage packets, store-queue entry, FSM states
package sys_defs;

  localparam int XLEN  = 32;
  localparam int PRF_W = 6;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } MEM_COMMAND;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } MEM_SIZE;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } RETIRE_STATE;

  typedef struct packed {
    logic             valid;
    logic [PRF_W-1:0] tag;
  } PHYS_TAG;

  typedef struct packed {
    logic            retire_en;
    PHYS_TAG         retire_t;
    PHYS_TAG         retire_t_old;
    logic            halt;
    logic            wr_mem;
    logic [4:0]      dest_reg_idx;
    logic [XLEN-1:0] NPC;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rs2_value;
    logic            take_branch;
    MEM_SIZE         mem_size;
  } ROB_IR_PACKET;

  typedef struct packed {
    logic             free_en;
    logic [PRF_W-1:0] free_t;
  } IR_FL_PACKET;

  typedef struct packed {
    logic             wr_en;
    logic [4:0]       idx;
    logic [PRF_W-1:0] t;
  } IR_MAP_PACKET;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    MEM_SIZE         size;
  } SQ_ENTRY;

endpackage

// File: rtl/retire_store_queue.sv
// rtl/retire_store_queue.sv - in-order circular store FIFO between retirement and the data memory port
module retire_store_queue
  import sys_defs::*;
#(
  parameter int SQ_DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  SQ_ENTRY                    push_entry,
  input  logic                       pop,
  output SQ_ENTRY                    head,
  output logic [$clog2(SQ_DEPTH):0]  count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(SQ_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(SQ_DEPTH);

  SQ_ENTRY          mem [SQ_DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[head_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push_ok) tail_ptr <= tail_ptr + 1'b1;
      if (pop_ok)  head_ptr <= head_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage needs no reset: reset empties the queue through the pointers.
  always_ff @(posedge clock) begin
    if (push_ok) mem[tail_ptr] <= push_entry;
  end

endmodule

// File: rtl/retire_stage.sv
// rtl/retire_stage.sv - retire stage: free/map/squash updates, store queue drain, halt FSM (option RETIRE_TRACE_EN)
module retire_stage
  import sys_defs::*;
#(
  parameter int SQ_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  ROB_IR_PACKET    rob_ir_packet,
  output logic            ir_rob_stall,
  output IR_FL_PACKET     ir_fl_packet,
  output IR_MAP_PACKET    ir_map_packet,
  output logic            squash_en,
  output logic [XLEN-1:0] squash_pc,
`ifdef RETIRE_TRACE_EN
  output logic            trace_valid,
  output logic [XLEN-1:0] trace_NPC,
  output logic [4:0]      trace_dest_reg_idx,
  output logic [XLEN-1:0] trace_result,
`endif
  output MEM_COMMAND      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [XLEN-1:0] proc2mem_data,
  output MEM_SIZE         proc2mem_size,
  input  logic            mem_store_ready,
  output logic [31:0]     retired_count,
  output logic            halted
);

  RETIRE_STATE                state;
  logic                       accept;
  logic                       normal;
  logic                       sq_push;
  logic                       sq_pop;
  logic                       sq_full;
  logic                       sq_empty;
  logic [$clog2(SQ_DEPTH):0]  sq_count;
  SQ_ENTRY                    push_entry;
  SQ_ENTRY                    sq_head;

  assign ir_rob_stall = (state != RUN) || sq_full;
  assign accept       = rob_ir_packet.retire_en && !ir_rob_stall;
  // A halt packet retires (and counts) but has no architectural side effects.
  assign normal       = accept && !rob_ir_packet.halt;
  assign sq_push      = normal && rob_ir_packet.wr_mem;
  assign sq_pop       = !sq_empty && mem_store_ready;
  assign push_entry   = '{addr: rob_ir_packet.result,
                          data: rob_ir_packet.rs2_value,
                          size: rob_ir_packet.mem_size};

  retire_store_queue #(.SQ_DEPTH(SQ_DEPTH)) u_sq (
    .clock      (clock),
    .reset      (reset),
    .push       (sq_push),
    .push_entry (push_entry),
    .pop        (sq_pop),
    .head       (sq_head),
    .count      (sq_count),
    .full       (sq_full),
    .empty      (sq_empty)
  );

  assign proc2mem_command = sq_empty ? BUS_NONE : BUS_STORE;
  assign proc2mem_addr    = sq_empty ? '0 : sq_head.addr;
  assign proc2mem_data    = sq_empty ? '0 : sq_head.data;
  assign proc2mem_size    = sq_empty ? BYTE : sq_head.size;
  assign halted           = (state == HALTED);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir_fl_packet  <= '0;
      ir_map_packet <= '0;
      squash_en     <= 1'b0;
      squash_pc     <= '0;
      retired_count <= '0;
    end else begin
      ir_fl_packet.free_en <= normal && rob_ir_packet.retire_t_old.valid;
      ir_fl_packet.free_t  <= rob_ir_packet.retire_t_old.tag;
      ir_map_packet.wr_en  <= normal && rob_ir_packet.retire_t.valid &&
                              (rob_ir_packet.dest_reg_idx != 5'd0);
      ir_map_packet.idx    <= rob_ir_packet.dest_reg_idx;
      ir_map_packet.t      <= rob_ir_packet.retire_t.tag;
      squash_en            <= accept && rob_ir_packet.take_branch;
      if (accept && rob_ir_packet.take_branch) squash_pc <= rob_ir_packet.result;
      if (accept) retired_count <= retired_count + 32'd1;
    end
  end

  // DRAIN sees the registered count, so HALTED follows the final pop by two edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (accept && rob_ir_packet.halt) state <= DRAIN;
        DRAIN:   if (sq_count == '0) state <= HALTED;
        default: state <= HALTED;
      endcase
    end
  end

`ifdef RETIRE_TRACE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trace_valid        <= 1'b0;
      trace_NPC          <= '0;
      trace_dest_reg_idx <= '0;
      trace_result       <= '0;
    end else begin
      trace_valid        <= accept;
      trace_NPC          <= rob_ir_packet.NPC;
      trace_dest_reg_idx <= rob_ir_packet.dest_reg_idx;
      trace_result       <= rob_ir_packet.result;
    end
  end
`else
  logic unused_npc;
  assign unused_npc = ^rob_ir_packet.NPC;
`endif

endmodule

// File: doc/retire_stage.md
# retire_stage

Retire stage directly downstream of the reorder buffer; it consumes the ROB head packet each cycle the head is complete. It frees the superseded physical tag, updates the architectural map, and redirects fetch on taken branches. Retired stores are buffered in a small in-order store queue that drains to the data memory port. A halt FSM stops retirement and drains all stores before asserting `halted`.

## Interface
- `SQ_DEPTH`, default 4: store-queue entries; power of two, ≥2.
- Width of data paths is the global `XLEN`.

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rob_ir_packet`  in  ROB_IR_PACKET  ROB head: `retire_en`, `retire_t`, `retire_t_old`, `halt`, `wr_mem`, `dest_reg_idx`, `NPC`, `result`, `rs2_value`, `take_branch`, `mem_size`.
- `ir_rob_stall`  out  1  ROB must not advance its head this cycle.
- `ir_fl_packet`  out  IR_FL_PACKET  `free_en`, `free_t`: tag returned to free list.
- `ir_map_packet`  out  IR_MAP_PACKET  `wr_en`, `idx[4:0]`, `t`: architectural map write.
- `squash_en`  out  1  taken-branch redirect pulse.
- `squash_pc`  out  XLEN  redirect target.
- `proc2mem_command`  out  MEM_COMMAND  BUS_STORE when the queue is non-empty, else BUS_NONE.
- `proc2mem_addr`  out  XLEN  queue-head address.
- `proc2mem_data`  out  XLEN  queue-head data.
- `proc2mem_size`  out  MEM_SIZE  queue-head size.
- `mem_store_ready`  in  1  memory accepts the presented store this cycle.
- `retired_count`  out  32  retired-instruction counter.
- `halted`  out  1  halt retired and all stores drained.

## Operation
- Accept = `retire_en && !ir_rob_stall`.
- `ir_rob_stall` = `(state != RUN) || (sq_count == SQ_DEPTH)`. Registered-state only; no combinational path from `rob_ir_packet`.
- On accept:
  - `retire_t_old.valid`: free `retire_t_old`.
  - `retire_t.valid && dest_reg_idx != 0`: map write `{dest_reg_idx, retire_t}`.
  - `take_branch`: `squash_en=1`, `squash_pc=result`.
  - `wr_mem`: push `{addr=result, data=rs2_value, size=mem_size}` at the tail.
  - `halt`: state RUN→DRAIN. The halt itself frees, maps and stores nothing.
  - `retired_count += 1`, including the halt.
- Store queue:
  - Head presented whenever the queue is non-empty; pop when `mem_store_ready` is high.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo `SQ_DEPTH`.
  - Push is never attempted when full, because stall prevents accept.
- FSM:
  - RUN: normal retirement.
  - DRAIN: no accepts. Go to HALTED in the cycle after the count reaches 0.
  - HALTED: sticky until reset.
- `retired_count` wraps at 2^32.

## Timing
- Accept in cycle N → `ir_fl_packet`, `ir_map_packet`, `squash_en/pc`, `retired_count` update are visible in N+1.
- Pulses last exactly one cycle.
- A store pushed at N appears on `proc2mem_*` no earlier than N+1. Order is strictly FIFO.
- `halted` rises at least one cycle after the last store pop.
- While `reset` is low, asynchronously:
  - `state`=RUN, queue empty, `retired_count`=0.
  - All `*_en`, `squash_pc`, `proc2mem_*` = 0 (command BUS_NONE).
  - `ir_rob_stall`=0, `halted`=0.
- Reset mid-drain discards queued stores.

## Configuration
- `RETIRE_TRACE_EN` defined: adds outputs `trace_valid`, `trace_NPC`, `trace_dest_reg_idx`, `trace_result`. They are registered with the same N+1 timing as `ir_map_packet`, for the testbench commit log.
- `RETIRE_TRACE_EN` undefined: these ports and their registers are absent. All other behaviour is identical.

## Structure
- `sys_defs` package holds:
  - ROB_IR_PACKET, with `mem_size` added.
  - IR_FL_PACKET and IR_MAP_PACKET.
  - SQ_ENTRY struct.
  - RETIRE_STATE enum {RUN, DRAIN, HALTED}.
- Sub-module `retire_store_queue`: circular FIFO with push, pop, head, count and full/empty.

## Test plan
- ALU op retire, t=P5, t_old=P2, idx=3 → next cycle free_t=P2, map {3,P5}, count=1.
- dest_reg_idx=0 with valid t → no map write; t_old still freed.
- Taken branch, result=0x100 → `squash_en` one-cycle pulse, `squash_pc`=0x100.
- 4 stores back-to-back, `mem_store_ready`=0 → stall after 4th; raise ready → addresses drain in order, stall drops as soon as count<4.
- Push+pop same cycle at count=2 → count stays 2; pointers wrap correctly over 10 stores.
- 2 pending stores then halt → stall immediately, `halted` only after both stores popped. Reset low mid-drain → all outputs 0 asynchronously.
